// File: rtl/bus_fabric_pkg.sv
// Shared types and helpers for the CPU-to-slave bus fabric.
package bus_fabric_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Operands are zero-extended to 32 bits so the helper serves any ADDR_W up to 32.
  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address decoder: the lowest-index window that matches wins.
module bus_region_decode
  import bus_fabric_pkg::*;
#(
  parameter int                          N_SLAVES   = 4,
  parameter int                          ADDR_W     = 16,
  parameter int                          SEL_W      = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0]  BASE_ADDRS = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]  ADDR_MASKS = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel,
  output logic              hit
);

  logic [N_SLAVES-1:0] hits;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_win
    assign hits[i] = region_hit(32'(addr),
                                32'(BASE_ADDRS[i*ADDR_W +: ADDR_W]),
                                32'(ADDR_MASKS[i*ADDR_W +: ADDR_W]));
  end

  // Walk from the top down so the lowest matching index is the last assignment.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        sel = SEL_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Bus fabric top: request FSM, per-slave wait counter, read-data mux and sticky error capture.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                            N_SLAVES    = 4,
  parameter int                            ADDR_W      = 16,
  parameter int                            DATA_W      = 8,
  parameter logic [N_SLAVES*ADDR_W-1:0]    BASE_ADDRS  = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [N_SLAVES*ADDR_W-1:0]    ADDR_MASKS  = {16'hF000, 16'hF000, 16'hFF00, 16'hF800},
  parameter logic [N_SLAVES*WAIT_W-1:0]    WAIT_STATES = {4'd0, 4'd1, 4'd0, 4'd0}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_din,
  input  logic                         m_w_en,
  input  logic                         m_r_en,
  output logic [DATA_W-1:0]            m_dout,
  output logic                         m_ready,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_din,
  output logic [N_SLAVES-1:0]          s_w_en,
  output logic [N_SLAVES-1:0]          s_r_en,
  input  logic [N_SLAVES*DATA_W-1:0]   s_dout,
  output logic                         bus_err,
  output logic [ADDR_W-1:0]            err_addr,
  input  logic                         err_clr
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, dec_sel;
  logic                dec_hit;
  logic                wr_q;
  logic                err_pend_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                req, illegal;

  bus_region_decode #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .addr (m_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign req     = m_w_en | m_r_en;
  assign illegal = (m_w_en & m_r_en) | ~dec_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      err_pend_q <= 1'b0;
      cnt_q      <= '0;
      s_addr     <= '0;
      s_din      <= '0;
      bus_err    <= 1'b0;
      err_addr   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req) begin
          s_addr     <= m_addr;
          s_din      <= m_din;
          wr_q       <= m_w_en;
          sel_q      <= dec_sel;
          err_pend_q <= illegal;
          // An unmapped access has no slave to wait on.
          cnt_q      <= dec_hit ? WAIT_STATES[dec_sel*WAIT_W +: WAIT_W] : '0;
        end
        WAIT:    cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      // A new error beats a simultaneous clear and recaptures its address.
      if (state_q == RESP && err_pend_q) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clr) err_addr <= s_addr;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_w_en  = '0;
    s_r_en  = '0;
    m_ready = 1'b0;
    m_dout  = '0;
    case (state_q)
      IDLE:   if (req) state_d = ACCESS;
      ACCESS: begin
        if (!err_pend_q) begin
          if (wr_q) s_w_en = N_SLAVES'(1) << sel_q;
          else      s_r_en = N_SLAVES'(1) << sel_q;
        end
        state_d = (cnt_q != '0) ? WAIT : RESP;
      end
      WAIT:   if (cnt_q == WAIT_W'(1)) state_d = RESP;
      RESP: begin
        m_ready = 1'b1;
        if (!wr_q && !err_pend_q) m_dout = s_dout[sel_q*DATA_W +: DATA_W];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric with the default four-window map.
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m_addr;
  logic [7:0]  m_din;
  logic        m_w_en, m_r_en;
  logic [7:0]  m_dout;
  logic        m_ready;
  logic [15:0] s_addr;
  logic [7:0]  s_din;
  logic [3:0]  s_w_en, s_r_en;
  logic [31:0] s_dout;
  logic        bus_err;
  logic [15:0] err_addr;
  logic        err_clr;

  int total  = 0;
  int passed = 0;

  bus_fabric dut (
    .clk      (clk),
    .rst      (rst),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_w_en   (m_w_en),
    .m_r_en   (m_r_en),
    .m_dout   (m_dout),
    .m_ready  (m_ready),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_w_en   (s_w_en),
    .s_r_en   (s_r_en),
    .s_dout   (s_dout),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_req();
    m_w_en = 1'b0;
    m_r_en = 1'b0;
  endtask

  initial begin
    // Fixed slave read data: slave3=77, slave2=C3, slave1=5A, slave0=A5.
    s_dout  = 32'h77C3_5AA5;
    rst     = 1'b1;
    m_addr  = '0;
    m_din   = '0;
    err_clr = 1'b0;
    idle_req();
    step();
    step();
    chk("rst_ready",   m_ready,  0);
    chk("rst_dout",    m_dout,   0);
    chk("rst_wen",     s_w_en,   0);
    chk("rst_ren",     s_r_en,   0);
    chk("rst_buserr",  bus_err,  0);
    chk("rst_erraddr", err_addr, 0);
    chk("rst_saddr",   s_addr,   0);
    chk("rst_sdin",    s_din,    0);
    rst = 1'b0;
    step();

    // Read slave 0, no wait states.
    m_addr = 16'h0005; m_r_en = 1'b1;
    step();
    chk("rd0_ren_c1",   s_r_en,  4'b0001);
    chk("rd0_wen_c1",   s_w_en,  0);
    chk("rd0_ready_c1", m_ready, 0);
    step();
    chk("rd0_ren_c2",   s_r_en,  0);
    chk("rd0_ready_c2", m_ready, 1);
    chk("rd0_dout_c2",  m_dout,  8'hA5);
    idle_req();
    step();
    chk("rd0_ready_idle", m_ready, 0);
    chk("rd0_dout_idle",  m_dout,  0);

    // Write slave 2, one wait state.
    m_addr = 16'h2010; m_din = 8'h3C; m_w_en = 1'b1;
    step();
    chk("wr2_wen_c1",   s_w_en,  4'b0100);
    chk("wr2_saddr",    s_addr,  16'h2010);
    chk("wr2_sdin",     s_din,   8'h3C);
    step();
    chk("wr2_wen_c2",   s_w_en,  0);
    chk("wr2_ready_c2", m_ready, 0);
    step();
    chk("wr2_ready_c3", m_ready, 1);
    chk("wr2_dout_c3",  m_dout,  0);
    idle_req();
    m_addr = 16'h0000; m_din = 8'h00;
    step();
    chk("wr2_saddr_hold", s_addr, 16'h2010);
    chk("wr2_sdin_hold",  s_din,  8'h3C);
    chk("wr2_no_err",     bus_err, 0);

    // Read slave 3 for mux coverage of the top window.
    m_addr = 16'h3FFF; m_r_en = 1'b1;
    step();
    chk("rd3_ren_c1", s_r_en, 4'b1000);
    step();
    chk("rd3_ready", m_ready, 1);
    chk("rd3_dout",  m_dout,  8'h77);
    idle_req();
    step();

    // Unmapped read: 0x0900 misses the 2 KB slave-0 window.
    m_addr = 16'h0900; m_r_en = 1'b1;
    step();
    chk("unm_ren_c1", s_r_en, 0);
    chk("unm_wen_c1", s_w_en, 0);
    step();
    chk("unm_ready", m_ready, 1);
    chk("unm_dout",  m_dout,  0);
    idle_req();
    step();
    chk("unm_buserr",  bus_err,  1);
    chk("unm_erraddr", err_addr, 16'h0900);

    // Second error must not overwrite the captured address.
    m_addr = 16'h4000; m_r_en = 1'b1;
    step();
    step();
    chk("unm2_ready", m_ready, 1);
    idle_req();
    step();
    chk("unm2_buserr",  bus_err,  1);
    chk("unm2_erraddr", err_addr, 16'h0900);

    // Clear coinciding with an error response: set wins, address reloads.
    m_addr = 16'h5000; m_r_en = 1'b1;
    step();
    step();
    chk("clr_set_ready", m_ready, 1);
    err_clr = 1'b1;
    idle_req();
    step();
    err_clr = 1'b0;
    chk("clr_set_buserr",  bus_err,  1);
    chk("clr_set_erraddr", err_addr, 16'h5000);

    // Plain clear.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_buserr",  bus_err,  0);
    chk("clr_erraddr", err_addr, 16'h5000);

    // Both enables high on a mapped address.
    m_addr = 16'h1002; m_w_en = 1'b1; m_r_en = 1'b1;
    step();
    chk("both_wen", s_w_en, 0);
    chk("both_ren", s_r_en, 0);
    step();
    chk("both_ready", m_ready, 1);
    chk("both_dout",  m_dout,  0);
    idle_req();
    step();
    chk("both_buserr",  bus_err,  1);
    chk("both_erraddr", err_addr, 16'h1002);

    // Reset while waiting on slave 2.
    m_addr = 16'h2000; m_r_en = 1'b1;
    step();
    chk("rstw_ren_c1", s_r_en, 4'b0100);
    step();
    chk("rstw_ready_wait", m_ready, 0);
    rst = 1'b1;
    idle_req();
    step();
    rst = 1'b0;
    chk("rstw_ready",  m_ready, 0);
    chk("rstw_ren",    s_r_en,  0);
    chk("rstw_buserr", bus_err, 0);
    m_addr = 16'h1001; m_r_en = 1'b1;
    step();
    chk("rstw_rd1_ren", s_r_en, 4'b0010);
    chk("rstw_rd1_rdy1", m_ready, 0);
    step();
    chk("rstw_rd1_ready", m_ready, 1);
    chk("rstw_rd1_dout",  m_dout,  8'h5A);
    idle_req();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
